// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_pkg
// Brief   : Shared types and constants for the FP-multiplier round-robin arbiter
// Revision: 1.0
// ============================================================================
package fpmul_pkg;

  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_NAN_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/fpmul_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Round-robin winner search starting at the requester after last_i
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         winner_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0] cand;

  // Walk NREQ positions after last_i with explicit wrap so non-power-of-two NREQ works
  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = last_i;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!valid_o && req_i[cand]) begin
        winner_o[cand] = 1'b1;
        idx_o          = cand;
        valid_o        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpmul_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_rr_arbiter
// Brief   : Round-robin sharing of one FP multiplier among NREQ requesters.
//           Define FPMUL_ARB_TIMEOUT_EN to enable the mul_done watchdog.
// Revision: 1.0
// ============================================================================
module fpmul_rr_arbiter
  import fpmul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_i,
  input  logic [FP_WIDTH*NREQ-1:0] op_a_i,
  input  logic [FP_WIDTH*NREQ-1:0] op_b_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [NREQ-1:0]          rsp_valid_o,
  output logic [FP_WIDTH-1:0]      rsp_c_o,
  output logic                     rsp_ovf_o,
  output logic                     mul_start_o,
  output logic [FP_WIDTH-1:0]      mul_a_o,
  output logic [FP_WIDTH-1:0]      mul_b_o,
  input  logic [FP_WIDTH-1:0]      mul_c_i,
  input  logic                     mul_ovf_i,
  input  logic                     mul_done_i
);

  localparam int PW = $clog2(NREQ);

  arb_state_e          state_q;
  logic [PW-1:0]       last_q;
  logic [PW-1:0]       win_idx_q;
  logic [NREQ-1:0]     win_oh_q;
  logic [NREQ-1:0]     grant_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic                mul_start_q;
  logic [FP_WIDTH-1:0] mul_a_q;
  logic [FP_WIDTH-1:0] mul_b_q;
  logic [FP_WIDTH-1:0] rsp_c_q;
  logic                rsp_ovf_q;

  logic [NREQ-1:0]     win_oh_d;
  logic [PW-1:0]       win_idx_d;
  logic                win_vld_d;
  logic [FP_WIDTH-1:0] op_a_d;
  logic [FP_WIDTH-1:0] op_b_d;

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt_q;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (win_oh_d),
    .idx_o    (win_idx_d),
    .valid_o  (win_vld_d)
  );

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_d == PW'(i)) begin
        op_a_d = op_a_i[i*FP_WIDTH +: FP_WIDTH];
        op_b_d = op_b_i[i*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  // Pulse outputs default low each cycle; each state raises at most one of them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PW'(NREQ - 1);
      win_idx_q   <= '0;
      win_oh_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_c_q     <= '0;
      rsp_ovf_q   <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      grant_q     <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            grant_q   <= win_oh_d;
            win_oh_q  <= win_oh_d;
            win_idx_q <= win_idx_d;
            mul_a_q   <= op_a_d;
            mul_b_q   <= op_b_d;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mul_start_q <= 1'b1;
          state_q     <= ST_WAIT;
`ifdef FPMUL_ARB_TIMEOUT_EN
          wait_cnt_q  <= '0;
`endif
        end
        ST_WAIT: begin
          if (mul_done_i) begin
            rsp_c_q   <= mul_c_i;
            rsp_ovf_q <= mul_ovf_i;
            state_q   <= ST_RESP;
          end
`ifdef FPMUL_ARB_TIMEOUT_EN
          else if (wait_cnt_q == CNT_LAST) begin
            rsp_c_q   <= FP_NAN_ALL_ONES;
            rsp_ovf_q <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_q <= win_oh_q;
          last_q      <= win_idx_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_c_o     = rsp_c_q;
  assign rsp_ovf_o   = rsp_ovf_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_fpmul_rr_arbiter.sv
`default_nettype none
// Testbench for fpmul_rr_arbiter: random operands and request masks against a
// round-robin/FP-multiply reference model, plus directed corner cases.
module tb_fpmul_rr_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req   = '0;
  logic [32*NREQ-1:0] op_a = '0;
  logic [32*NREQ-1:0] op_b = '0;
  logic [NREQ-1:0]   grant_o, rsp_valid_o;
  logic [31:0]       rsp_c_o, mul_a_o, mul_b_o;
  logic              rsp_ovf_o, mul_start_o;
  logic [31:0]       mul_c    = '0;
  logic              mul_ovf  = 1'b0;
  logic              mul_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mul_lat  = 5;
  bit mul_en   = 1'b1;
  int late_req = 0;
  int last_win = NREQ - 1;

  typedef struct {int idx; logic [31:0] c; logic ovf; int cyc;} rsp_t;
  int   gq_idx[$];
  int   gq_cyc[$];
  rsp_t rq[$];
  rsp_t last_rsp;

  fpmul_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .grant_o     (grant_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_c_o     (rsp_c_o),
    .rsp_ovf_o   (rsp_ovf_o),
    .mul_start_o (mul_start_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_c_i     (mul_c),
    .mul_ovf_i   (mul_ovf),
    .mul_done_i  (mul_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Truncating single-precision multiply for normal operands; overflow saturates to all-ones.
  function automatic void fmul(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] c, output logic ovf);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    ovf = 1'b0;
    if (e >= 255) begin c = 32'hFFFF_FFFF; ovf = 1'b1; end
    else if (e <= 0) c = {a[31] ^ b[31], 31'b0};
    else c = {a[31] ^ b[31], 8'(e), m};
  endfunction

  function automatic int rr_next(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*32 +: 32] = rand_fp();
      op_b[i*32 +: 32] = rand_fp();
    end
  endtask

  // Monitor: log grants and responses, and check one-hotness every cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("onehot", 32'({$onehot0(grant_o), $onehot0(rsp_valid_o)}), 32'd3);
      if (grant_o != '0) begin gq_idx.push_back(oh2i(grant_o)); gq_cyc.push_back(cyc); end
      if (rsp_valid_o != '0) rq.push_back('{oh2i(rsp_valid_o), rsp_c_o, rsp_ovf_o, cyc});
    end
  end

  // Shared multiplier model with programmable latency.
  initial begin
    int pend, late_seen;
    logic [31:0] rc;
    logic ro;
    pend = 0; late_seen = 0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (late_req != late_seen) begin
        late_seen = late_req;
        mul_done = 1'b1; mul_c = 32'h1234_5678; mul_ovf = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin mul_done = 1'b1; mul_c = rc; mul_ovf = ro; end
      end else if (mul_en && mul_start_o) begin
        fmul(mul_a_o, mul_b_o, rc, ro);
        pend = mul_lat;
      end
    end
  end

  task automatic wait_grant(output int idx, output int gc);
    bit got;
    got = 1'b0; idx = -1; gc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (gq_idx.size() > 0) begin idx = gq_idx.pop_front(); gc = gq_cyc.pop_front(); got = 1'b1; end
    end
    check("grant_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(output rsp_t r);
    bit got;
    got = 1'b0; r = '{-1, 32'h0, 1'b0, 0};
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk); #1;
      if (rq.size() > 0) begin r = rq.pop_front(); got = 1'b1; end
    end
    check("rsp_seen", 32'(got), 32'd1);
  endtask

  task automatic txn(input string tag, input logic [NREQ-1:0] mask, input bit perturb);
    int w, gc, c0, ew;
    rsp_t r;
    logic [31:0] ea, eb, xc;
    logic xo;
    ew = rr_next(mask, last_win);
    c0 = cyc;
    req = mask;
    wait_grant(w, gc);
    check({tag, "_gnt"}, 32'(w), 32'(ew));
    check({tag, "_glat"}, 32'(gc - c0), 32'd1);
    ea = op_a[ew*32 +: 32];
    eb = op_b[ew*32 +: 32];
    fmul(ea, eb, xc, xo);
    @(negedge clk); #1;
    check({tag, "_start"}, 32'({mul_start_o, grant_o}), 32'({1'b1, 4'b0}));
    if (perturb) begin
      op_a[ew*32 +: 32] = ~ea;
      op_b[ew*32 +: 32] = rand_fp();
    end
    req = '0;
    wait_rsp(r);
    check({tag, "_ridx"}, 32'(r.idx), 32'(ew));
    check({tag, "_c"}, r.c, xc);
    check({tag, "_ovf"}, 32'(r.ovf), 32'(xo));
    check({tag, "_lat"}, 32'(r.cyc - gc), 32'(3 + mul_lat));
    last_rsp = r;
    last_win = ew;
  endtask

  initial begin
    int w, gc, ew, prev_rc;
    rsp_t r;
    logic [31:0] xc;
    logic xo;

    // Asynchronous reset forces all outputs low immediately
    #2 reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_rspv", 32'(rsp_valid_o), 32'd0);
    check("rst_start", 32'(mul_start_o), 32'd0);
    check("rst_mul_a", mul_a_o, 32'd0);
    check("rst_mul_b", mul_b_o, 32'd0);
    check("rst_rsp_c", rsp_c_o, 32'd0);
    check("rst_ovf", 32'(rsp_ovf_o), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;

    // Requester 2 alone: 1.0 * 2.0
    mul_lat = 5;
    op_a[2*32 +: 32] = 32'h3F80_0000;
    op_b[2*32 +: 32] = 32'h4000_0000;
    txn("r2_basic", 4'b0100, 1'b0);
    check("r2_c_const", last_rsp.c, 32'h4000_0000);

    // Overflowing product on requester 1
    op_a[1*32 +: 32] = 32'h7F00_0000;
    op_b[1*32 +: 32] = 32'h7F00_0000;
    txn("r1_ovf", 4'b0010, 1'b0);
    check("r1_ovf_c", last_rsp.c, 32'hFFFF_FFFF);
    check("r1_ovf_f", 32'(last_rsp.ovf), 32'd1);

    // Requester 3 drops req and changes operands after grant
    rand_ops();
    txn("r3_drop", 4'b1000, 1'b1);

    // All requesters held high: strict rotation and back-to-back service
    rand_ops();
    mul_lat = 2;
    req = 4'b1111;
    prev_rc = 0;
    for (int i = 0; i < 8; i++) begin
      wait_grant(w, gc);
      check("fair_gnt", 32'(w), 32'(i % NREQ));
      if (i > 0) check("fair_b2b", 32'(gc - prev_rc), 32'd1);
      wait_rsp(r);
      if (i == 7) req = '0;
      fmul(op_a[(i % NREQ)*32 +: 32], op_b[(i % NREQ)*32 +: 32], xc, xo);
      check("fair_ridx", 32'(r.idx), 32'(i % NREQ));
      check("fair_c", r.c, xc);
      prev_rc = r.cyc;
    end
    last_win = NREQ - 1;

    // Requests raised while busy are held until the arbiter is idle
    rand_ops();
    mul_lat = 4;
    req = 4'b0010;
    wait_grant(w, gc);
    check("pend_g1", 32'(w), 32'd1);
    @(negedge clk); #1 req = '0;
    repeat (2) @(negedge clk);
    #1 req = 4'b0101;
    wait_rsp(r);
    check("pend_no_early", 32'(gq_idx.size()), 32'd0);
    check("pend_r1", 32'(r.idx), 32'd1);
    ew = rr_next(4'b0101, 1);
    wait_grant(w, gc);
    check("pend_g2", 32'(w), 32'(ew));
    check("pend_g2_lat", 32'(gc - r.cyc), 32'd1);
    @(negedge clk); #1 req = '0;
    wait_rsp(r);
    fmul(op_a[ew*32 +: 32], op_b[ew*32 +: 32], xc, xo);
    check("pend_c2", r.c, xc);
    last_win = ew;

    // Random masks, operands and multiplier latencies
    for (int n = 0; n < 12; n++) begin
      rand_ops();
      mul_lat = int'($urandom_range(1, 6));
      txn("rnd", 4'($urandom_range(1, 15)), 1'($urandom));
    end

    // Reset during WAIT abandons the operation; late mul_done is ignored
    mul_lat = 3;
    txn("pre_rst", 4'b0010, 1'b0);
    mul_en = 1'b0;
    req = 4'b0100;
    wait_grant(w, gc);
    check("rst_wait_gnt", 32'(w), 32'd2);
    @(negedge clk); #1 req = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rstw_mul_a", mul_a_o, 32'd0);
    check("rstw_rsp_c", rsp_c_o, 32'd0);
    check("rstw_ovf", 32'(rsp_ovf_o), 32'd0);
    @(negedge clk); #1 reset = 1'b1;
    last_win = NREQ - 1;
    repeat (2) @(negedge clk);
    #1 late_req++;
    repeat (6) @(negedge clk);
    #1;
    check("rst_no_rsp", 32'(rq.size()), 32'd0);
    mul_en = 1'b1;
    rand_ops();
    txn("post_rst", 4'b1111, 1'b0);

`ifdef FPMUL_ARB_TIMEOUT_EN
    // Watchdog: no mul_done ever
    mul_en = 1'b0;
    req = 4'b0001;
    wait_grant(w, gc);
    req = '0;
    wait_rsp(r);
    check("tmo_idx", 32'(r.idx), 32'd0);
    check("tmo_lat", 32'(r.cyc - gc), 32'(TMO + 2));
    check("tmo_c", r.c, 32'hFFFF_FFFF);
    check("tmo_ovf", 32'(r.ovf), 32'd1);
    mul_en = 1'b1;
    last_win = 0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
